// File: rtl/edge_window_filter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_window_filter
//  Description : Streaming 3x3 window filter over a raster-order image.
//                Two line buffers plus a 3x3 window feed either a median
//                or a Gaussian (1-2-1 kernel, rounded) datapath. One
//                registered output per interior pixel, valid/ready on both
//                sides, frame_done pulse once the last output is taken.
//  Options     : EDGE_WINDOW_GAUSS_EN -- when defined, the Gaussian
//                datapath is built and 'mode' (latched at pixel 0,0)
//                selects it; when undefined, median is always used.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_window_filter #(
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 20,
  parameter int BIT_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_LENGTH-1:0] pixel_out,
  output logic                  frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic                  out_valid_q;
  logic                  frame_done_q;
  logic [BIT_LENGTH-1:0] pixel_out_q;

  // lb0 holds row r-1, lb1 holds row r-2, indexed by column
  logic [BIT_LENGTH-1:0] lb0_q [0:IMG_W-1];
  logic [BIT_LENGTH-1:0] lb1_q [0:IMG_W-1];
  // Two previous columns of the window: [row][0] = col-2, [row][1] = col-1
  logic [BIT_LENGTH-1:0] win_q [0:2][0:1];

  logic                  w_accept;
  logic                  w_emit;
  logic                  w_last;
  logic [BIT_LENGTH-1:0] w_col [0:2];
  logic [BIT_LENGTH-1:0] w_win [0:8];
  logic [BIT_LENGTH-1:0] w_median;
  logic [BIT_LENGTH-1:0] w_result;

  assign in_ready   = (state_q == S_ACTIVE) && (!out_valid_q || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_emit     = w_accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign w_last     = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
  assign out_valid  = out_valid_q;
  assign pixel_out  = pixel_out_q;
  assign frame_done = frame_done_q;

  // Assemble the full 3x3 window (row-major) from stored columns plus the incoming column
  always_comb begin
    w_col[0] = lb1_q[col_q];
    w_col[1] = lb0_q[col_q];
    w_col[2] = pixel_in;
    for (int r = 0; r < 3; r++) begin
      w_win[r*3 + 0] = win_q[r][0];
      w_win[r*3 + 1] = win_q[r][1];
      w_win[r*3 + 2] = w_col[r];
    end
  end

  // Median by rank: the value with at most 4 strictly smaller and at least 5 not-larger entries
  always_comb begin
    logic [3:0] lt;
    logic [3:0] le;
    w_median = '0;
    for (int i = 0; i < 9; i++) begin
      lt = 4'd0;
      le = 4'd0;
      for (int j = 0; j < 9; j++) begin
        if (w_win[j] <  w_win[i]) lt = lt + 4'd1;
        if (w_win[j] <= w_win[i]) le = le + 4'd1;
      end
      if ((lt <= 4'd4) && (le >= 4'd5)) w_median = w_win[i];
    end
  end

`ifdef EDGE_WINDOW_GAUSS_EN
  localparam int GW = BIT_LENGTH + 4;

  logic                  mode_q;
  logic [GW-1:0]         w_gsum;
  logic [BIT_LENGTH-1:0] w_gauss;

  // Weighted sum with +8 rounding; 16*max+8 still fits GW bits
  always_comb begin
    w_gsum = GW'(w_win[0])        + (GW'(w_win[1]) << 1) + GW'(w_win[2])
           + (GW'(w_win[3]) << 1) + (GW'(w_win[4]) << 2) + (GW'(w_win[5]) << 1)
           + GW'(w_win[6])        + (GW'(w_win[7]) << 1) + GW'(w_win[8])
           + GW'(8);
    w_gauss = w_gsum[GW-1:4];
  end

  assign w_result = mode_q ? w_gauss : w_median;

  // Filter selection is frozen at the first pixel of each frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (w_accept && (row_q == '0) && (col_q == '0)) begin
      mode_q <= mode;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign w_result    = w_median;
`endif

  // Line buffers and window shift on every accepted pixel; contents need no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pixel_in;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= w_col[r];
      end
    end
  end

  // Frame FSM, raster counters and registered output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      pixel_out_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // in_ready guarantees the register is free or being drained when emitting
      if (w_emit) begin
        out_valid_q <= 1'b1;
        pixel_out_q <= w_result;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          state_q <= S_ACTIVE;
          col_q   <= '0;
          row_q   <= '0;
        end
        S_ACTIVE: begin
          if (w_accept) begin
            if (w_last) begin
              state_q <= S_DRAIN;
              col_q   <= '0;
              row_q   <= '0;
            end else if (col_q == C_LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          // The last pixel always produces an output, so wait for it to leave
          if (out_valid_q && out_ready) begin
            state_q      <= S_IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_window_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_window_filter
//  Description : Self-checking bench for edge_window_filter. A table of
//                frame records drives whole images; a reference model
//                pushes expected outputs into a queue as pixels are
//                accepted and the queue is popped as outputs are taken.
//                Hand-written sequences cover reset state, back-pressure
//                hold and mid-frame asynchronous reset.
//  Options     : EDGE_WINDOW_GAUSS_EN selects Gaussian expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_window_filter;

  localparam int W     = 20;
  localparam int H     = 20;
  localparam int B     = 5;
  localparam int N_OUT = (W - 2) * (H - 2);

`ifdef EDGE_WINDOW_GAUSS_EN
  localparam bit GAUSS = 1'b1;
`else
  localparam bit GAUSS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] pixel_in;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] pixel_out;
  logic         frame_done;

  always #5 clk = ~clk;

  edge_window_filter #(
    .IMG_W      (W),
    .IMG_H      (H),
    .BIT_LENGTH (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;
  int img [0:H-1][0:W-1];
  int exp_q [$];

  typedef struct {
    int bg;       // background value (ignored when rnd_img)
    int imp;      // impulse value at (5,5), -1 for none
    int mode0;    // mode driven for pixels 0..99
    int mode1;    // mode driven from pixel 100 on
    bit rnd_img;  // random image
    bit bp;       // random in_valid / out_ready
    bit stall;    // 10-cycle out_ready hold at pixel 105
    int exp55;    // required output centred at (5,5), -1 to skip
  } vec_t;

  vec_t vecs [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int median9(input int r, input int c);
    int v [0:8];
    int t;
    for (int i = 0; i < 9; i++) v[i] = img[r - 1 + i / 3][c - 1 + i % 3];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  function automatic int gauss9(input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img[r+dr][c+dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
    return (s + 8) >> 4;
  endfunction

  // Drive one frame; stop_after > 0 abandons it once that many pixels were accepted
  task automatic run_frame(input vec_t v, input int stop_after);
    int  k = 0, nout = 0, ndone = 0, cyc = 0, stall_cnt = 0, e = 0;
    int  model_mode = 0;
    bit  done = 1'b0, stalling;
    logic [B-1:0] cap = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v.rnd_img ? int'($urandom_range(0, (1 << B) - 1)) : v.bg;
    if (v.imp >= 0) img[5][5] = v.imp;
    exp_q.delete();
    while (!done) begin
      @(negedge clk);
      if (k < W * H) begin
        in_valid = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        pixel_in = B'(img[k / W][k % W]);
        mode     = (k < 100) ? v.mode0[0] : v.mode1[0];
      end else begin
        in_valid = 1'b0;
      end
      stalling = v.stall && (k == 105) && (stall_cnt < 10);
      if (stalling) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (stalling) begin
        if (stall_cnt == 1) begin
          cap = pixel_out;
          check("stall_valid", {31'd0, out_valid}, 32'd1);
        end else begin
          check("stall_hold", {30'd0, out_valid, in_ready}, 32'd2);
          check("stall_pixel", 32'(pixel_out), 32'(cap));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'(pixel_out), 32'(e));
          if (nout == 4 * (W - 2) + 4 && v.exp55 >= 0)
            check("centre_5_5", 32'(pixel_out), 32'(v.exp55));
        end
        nout++;
      end
      if (frame_done) begin
        ndone++;
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        done = 1'b1;
      end
      if (in_valid && in_ready) begin
        if (k == 0) model_mode = v.mode0;
        if ((k / W) >= 2 && (k % W) >= 2)
          exp_q.push_back((model_mode != 0 && GAUSS) ? gauss9(k / W - 1, k % W - 1)
                                                     : median9(k / W - 1, k % W - 1));
        k++;
        if (stop_after > 0 && k == stop_after) done = 1'b1;
      end
      cyc++;
      if (cyc > 5000) begin
        check("frame_timeout", 32'(cyc), 32'd0);
        done = 1'b1;
      end
    end
    if (stop_after == 0) begin
      check("out_count", 32'(nout), 32'(N_OUT));
      check("frame_done_count", 32'(ndone), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      #1;
      check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    end
  endtask

  initial begin
    //          bg imp m0 m1 rnd bp stall exp55
    vecs[0] = '{7,  -1, 0, 0, 0, 0, 0, 7};
    vecs[1] = '{0,  31, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0,  16, 1, 1, 0, 0, 0, (GAUSS ? 4 : 0)};
    vecs[3] = '{9,  31, 0, 1, 0, 0, 0, 9};
    vecs[4] = '{0,  -1, 0, 0, 1, 1, 0, -1};
    vecs[5] = '{0,  -1, 1, 1, 1, 1, 0, -1};
    vecs[6] = '{0,  -1, 0, 0, 1, 0, 1, -1};
    vecs[7] = '{3,  -1, 0, 0, 0, 0, 0, 3};

    reset     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pixel_in  = '0;
    #12;
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_in_ready",   {31'd0, in_ready},   32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_pixel_out",  32'(pixel_out),      32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_after_reset", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("active_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], 0);

    // Mid-frame asynchronous reset after 150 accepted pixels
    run_frame('{5, -1, 0, 0, 0, 0, 0, -1}, 150);
    @(posedge clk);
    #2;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_out_valid",  {31'd0, out_valid},  32'd0);
    check("async_pixel_out",  32'(pixel_out),      32'd0);
    check("async_in_ready",   {31'd0, in_ready},   32'd0);
    check("async_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    run_frame(vecs[7], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_window_filter.md
EDGE_WINDOW_FILTER -- requirements
Module: edge_window_filter

Interface
REQ-001 SHALL provide parameter IMG_W, default 20, image width in pixels (>=3).
REQ-002 SHALL provide parameter IMG_H, default 20, image height in pixels (>=3).
REQ-003 SHALL provide parameter BIT_LENGTH, default 5, pixel width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  1  filter select: 0 = 3x3 median, 1 = 3x3 Gaussian.
REQ-007 SHALL have port in_valid  input  1  pixel_in is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts pixel_in this cycle.
REQ-009 SHALL have port pixel_in  input  BIT_LENGTH  raster-order input pixel.
REQ-010 SHALL have port out_valid  output  1  pixel_out is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts pixel_out.
REQ-012 SHALL have port pixel_out  output  BIT_LENGTH  filtered interior pixel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after last output of a frame is accepted.

Function
REQ-014 SHALL accept a pixel when in_valid && in_ready, advancing col (0..IMG_W-1) then row (0..IMG_H-1) counters.
REQ-015 SHALL buffer the two previous rows in two IMG_W-entry line buffers plus a 3x3 window register.
REQ-016 SHALL emit one output per accepted pixel at row>=2 and col>=2, giving (IMG_W-2)*(IMG_H-2) outputs per frame, in raster order, centred on (row-1,col-1).
REQ-017 SHALL register the output: out_valid asserts the cycle after the completing pixel is accepted (latency 1).
REQ-018 SHALL drive in_ready = !out_valid || out_ready, in state ACTIVE only.
REQ-019 SHALL hold pixel_out and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL implement states IDLE, ACTIVE, DRAIN: IDLE->ACTIVE unconditionally after reset release (in_ready high); ACTIVE->DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1); DRAIN->IDLE when final output is accepted; IDLE->ACTIVE next cycle.
REQ-021 SHALL deassert in_ready in DRAIN and IDLE.
REQ-022 SHALL pulse frame_done for exactly one cycle on the DRAIN->IDLE transition, then clear counters for the next frame.
REQ-023 SHALL latch mode on acceptance of pixel (0,0); mode changes mid-frame SHALL be ignored.
REQ-024 SHALL compute median as the 5th smallest of the 9 window values (ties resolved by value, exact).
REQ-025 SHALL compute Gaussian as (sum of window x [1 2 1;2 4 2;1 2 1] + 8) >> 4, using BIT_LENGTH+4-bit internal width; result always fits BIT_LENGTH bits.
REQ-026 SHALL accept simultaneous input acceptance and output acceptance in one cycle without loss or duplication.

Reset
REQ-027 SHALL on reset low immediately clear state to IDLE, counters to 0, out_valid, in_ready, frame_done to 0, pixel_out to 0, latched mode to 0.
REQ-028 SHALL abandon any partial frame on mid-frame reset; the next frame restarts at pixel (0,0); line buffer contents need not be cleared.

Configuration
REQ-029 SHALL support macro EDGE_WINDOW_GAUSS_EN: defined -> both filters present, mode honoured; undefined -> Gaussian datapath absent, mode ignored, median always used.

Verification
REQ-030 20x20 frame all pixels 7, mode 0, out_ready=1 -> 324 outputs all 7, one frame_done pulse.
REQ-031 20x20 zeros with 31 at (5,5), mode 0 -> all 324 outputs 0.
REQ-032 20x20 zeros with 16 at (5,5), mode 1 (macro defined) -> output centred (5,5)=4, (5,6)=2, (6,6)=1, others 0.
REQ-033 out_ready low 10 cycles mid-frame -> out_valid held, pixel_out stable, in_ready low; stream resumes with no lost or repeated output.
REQ-034 reset low after 150 accepted pixels -> all outputs 0 asynchronously; fresh constant-3 frame then yields 324 outputs of 3.
REQ-035 mode toggled 0->1 at pixel 100 of constant-9 frame with 31 impulse -> whole frame filtered as median.
